dft_accumulation_tdm: RTL and testbench
=======================================

DFT_ACCUMULATION_TDM -- requirements
Module: dft_accumulation_tdm

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 16: I/Q sample width, signed.
REQ-002 SHALL have parameter WINDOW_WIDTH, default 18: window coefficient width, signed integer.
REQ-003 SHALL have parameter OSC_WIDTH, default 18: oscillator component width, signed Q1.(OSC_WIDTH-2), 1.0 = 2^(OSC_WIDTH-2).
REQ-004 SHALL have parameter ACCUM_WIDTH, default 48: accumulator component width, signed.
REQ-005 SHALL have parameter NUM_BINS, default 16: bin count, integer multiple of LANES.
REQ-006 SHALL have parameter LANES, default 4: parallel complex MAC lanes; G = NUM_BINS/LANES sweep groups.
REQ-007 SHALL have parameter SAMPLE_COUNT_WIDTH, default 16: sample counter width.
REQ-008 SHALL have ports: clk_i in 1 clock; rst_i in 1 synchronous active-high reset; start_i in 1 begin/abort-and-restart; E_real_i/E_imag_i in OSC_WIDTH x NUM_BINS per-bin step phasors; sample_valid_i in 1; sample_ready_o out 1; last_sample_i in 1 qualifies the accepted sample; i_sample_i/q_sample_i in IQ_WIDTH; window_coeff_i in WINDOW_WIDTH; out_valid_o out 1; out_ready_i in 1; out_bin_o out $clog2(NUM_BINS); out_real_o/out_imag_o out ACCUM_WIDTH; sample_count_o out SAMPLE_COUNT_WIDTH; busy_o out 1; overflow_o out 1.

Function
REQ-009 SHALL implement states IDLE, ACCUM, SWEEP, DRAIN.
REQ-010 start_i SHALL have priority in every state: next cycle ACCUM, all A=0, all W=(2^(OSC_WIDTH-2),0), E latched per bin, sample_count_o=0, overflow_o=0.
REQ-011 sample_ready_o SHALL be 1 only in ACCUM; transfer = sample_valid_i & sample_ready_o; accepted I, Q, h, last flag SHALL be registered.
REQ-012 After a transfer, SWEEP SHALL last exactly G+2 cycles (ready low), then return to ACCUM, or DRAIN if the last flag was set.
REQ-013 Per sweep, group g SHALL process bins g*LANES..g*LANES+LANES-1: xw = (I*h, Q*h) at full width; A += (xw*W) >>> S, S = max(0, IQ_WIDTH+WINDOW_WIDTH+OSC_WIDTH+1-ACCUM_WIDTH), arithmetic shift.
REQ-014 W update SHALL be W' = (W*E + 2^(OSC_WIDTH-3)) >>> (OSC_WIDTH-2), saturated to +/-(2^(OSC_WIDTH-1)-1); each W used before its own update within a sweep.
REQ-015 sample_count_o SHALL increment per transfer, saturating at all-ones.
REQ-016 DRAIN SHALL present bins 0..NUM_BINS-1 in order, one per out_valid_o & out_ready_i; out_* stable while stalled; IDLE after bin NUM_BINS-1 is accepted.
REQ-017 busy_o SHALL be 1 in any state except IDLE; sample_valid_i outside ACCUM SHALL be ignored.

Reset
REQ-018 On rst_i at a clock edge: IDLE, A/W/E/count zero, all outputs 0; reset SHALL override start_i and abort any sweep or drain without a partial output.

Configuration
REQ-019 With DFT_ACC_SAT_EN defined, accumulator adds SHALL saturate to +/-(2^(ACCUM_WIDTH-1)-1 / -2^(ACCUM_WIDTH-1)) and set sticky overflow_o until start_i/rst_i; undefined, adds SHALL wrap modulo 2^ACCUM_WIDTH and overflow_o SHALL be tied 0.

Verification (defaults)
REQ-020 Reset mid-SWEEP -> next cycle all outputs 0, state IDLE, sample_ready_o 0.
REQ-021 DC: E=(65536,0) all bins, 4 samples I=1000 Q=0 h=1 last on 4th -> every bin A=(8192000,0), sample_count_o=4.
REQ-022 Rotation: E=(0,65536) all bins, same 4 samples -> every bin A=(0,0).
REQ-023 Handshake: valid held high continuously -> sample_ready_o low exactly 6 cycles after each transfer, no duplicate acceptance.
REQ-024 Drain: out_ready_i low 3 cycles while out_bin_o=5 -> out_* stable, bins 0..15 each exactly once, then busy_o=0.
REQ-025 Saturation: E=(65536,0), 20 samples I=32767 h=131071 -> with DFT_ACC_SAT_EN A_real=2^47-1, overflow_o=1; without, wrapped value, overflow_o=0.

Source files
------------

// File: rtl/dft_accumulation_tdm_if.sv
// Sample-in and bin-out stream bundle for dft_accumulation_tdm.
interface dft_accumulation_tdm_if #(
  parameter int IQ_WIDTH     = 16,
  parameter int WINDOW_WIDTH = 18,
  parameter int ACCUM_WIDTH  = 48,
  parameter int NUM_BINS     = 16
);
  localparam int BW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  logic                           sample_valid_i;
  logic                           sample_ready_o;
  logic                           last_sample_i;
  logic signed [IQ_WIDTH-1:0]     i_sample_i;
  logic signed [IQ_WIDTH-1:0]     q_sample_i;
  logic signed [WINDOW_WIDTH-1:0] window_coeff_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [BW-1:0]                  out_bin_o;
  logic signed [ACCUM_WIDTH-1:0]  out_real_o;
  logic signed [ACCUM_WIDTH-1:0]  out_imag_o;

  modport master (
    output sample_valid_i,
    output last_sample_i,
    output i_sample_i,
    output q_sample_i,
    output window_coeff_i,
    output out_ready_i,
    input  sample_ready_o,
    input  out_valid_o,
    input  out_bin_o,
    input  out_real_o,
    input  out_imag_o
  );

  modport slave (
    input  sample_valid_i,
    input  last_sample_i,
    input  i_sample_i,
    input  q_sample_i,
    input  window_coeff_i,
    input  out_ready_i,
    output sample_ready_o,
    output out_valid_o,
    output out_bin_o,
    output out_real_o,
    output out_imag_o
  );
endinterface

// File: rtl/dft_accumulation_tdm.sv
// Time-multiplexed windowed DFT accumulator with LANES complex MACs.
// Define DFT_ACC_SAT_EN for saturating accumulators and sticky overflow.
module dft_accumulation_tdm #(
  parameter int IQ_WIDTH           = 16,
  parameter int WINDOW_WIDTH       = 18,
  parameter int OSC_WIDTH          = 18,
  parameter int ACCUM_WIDTH        = 48,
  parameter int NUM_BINS           = 16,
  parameter int LANES              = 4,
  parameter int SAMPLE_COUNT_WIDTH = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic [NUM_BINS-1:0][OSC_WIDTH-1:0]   E_real_i,
  input  logic [NUM_BINS-1:0][OSC_WIDTH-1:0]   E_imag_i,
  dft_accumulation_tdm_if.slave                io,
  output logic [SAMPLE_COUNT_WIDTH-1:0]        sample_count_o,
  output logic                                 busy_o,
  output logic                                 overflow_o
);

  localparam int G   = NUM_BINS / LANES;
  localparam int BW  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int CW  = $clog2(G + 2);
  localparam int GW  = (G > 1) ? $clog2(G) : 1;
  localparam int XW  = IQ_WIDTH + WINDOW_WIDTH;
  localparam int MW  = XW + OSC_WIDTH;
  localparam int PW  = MW + 1;
  localparam int SR  = (PW > ACCUM_WIDTH) ? PW - ACCUM_WIDTH : 0;
  localparam int FR  = OSC_WIDTH - 2;
  localparam int NW  = 2 * OSC_WIDTH;
  localparam int OW  = NW + 1;

  localparam logic signed [OSC_WIDTH-1:0] W_ONE =
    OSC_WIDTH'(1 << (OSC_WIDTH - 2));
  localparam logic signed [OSC_WIDTH-1:0] W_MAX =
    OSC_WIDTH'((1 << (OSC_WIDTH - 1)) - 1);
  localparam logic signed [OSC_WIDTH-1:0] W_MIN = -W_MAX;
  localparam logic signed [OW-1:0] W_HI  = OW'(W_MAX);
  localparam logic signed [OW-1:0] W_LO  = OW'(W_MIN);
  localparam logic signed [OW-1:0] W_RND = OW'(1 << (OSC_WIDTH - 3));

  typedef enum logic [1:0] {IDLE, ACCUM, SWEEP, DRAIN} state_t;

  state_t st, st_n;

  logic [CW-1:0] cnt;
  logic [GW-1:0] grp;
  logic [BW-1:0] idx;
  logic [SAMPLE_COUNT_WIDTH-1:0] count;

  logic signed [IQ_WIDTH-1:0]     x_i, x_q;
  logic signed [WINDOW_WIDTH-1:0] x_h;
  logic                           x_last;
  logic signed [XW-1:0]           xw_re, xw_im;

  logic signed [ACCUM_WIDTH-1:0] a_re [NUM_BINS];
  logic signed [ACCUM_WIDTH-1:0] a_im [NUM_BINS];
  logic signed [OSC_WIDTH-1:0]   w_re [NUM_BINS];
  logic signed [OSC_WIDTH-1:0]   w_im [NUM_BINS];
  logic signed [OSC_WIDTH-1:0]   e_re [NUM_BINS];
  logic signed [OSC_WIDTH-1:0]   e_im [NUM_BINS];

  logic [BW-1:0]                 lane_bin  [LANES];
  logic signed [ACCUM_WIDTH-1:0] lane_a_re [LANES];
  logic signed [ACCUM_WIDTH-1:0] lane_a_im [LANES];
  logic signed [OSC_WIDTH-1:0]   lane_w_re [LANES];
  logic signed [OSC_WIDTH-1:0]   lane_w_im [LANES];

  logic rdy, ovld, xfer, acc_out;

  function automatic logic signed [OSC_WIDTH-1:0] wsat(
    input logic signed [OW-1:0] v
  );
    if (v > W_HI)      return W_MAX;
    else if (v < W_LO) return W_MIN;
    else               return v[OSC_WIDTH-1:0];
  endfunction

`ifdef DFT_ACC_SAT_EN
  localparam int AW1 = ACCUM_WIDTH + 1;
  localparam logic signed [ACCUM_WIDTH-1:0] A_MAX =
    {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH-1:0] A_MIN =
    {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

  logic       ovf;
  logic [LANES-1:0] lane_ovf;

  function automatic logic signed [ACCUM_WIDTH-1:0] asat(
    input logic signed [AW1-1:0] s
  );
    if (s[AW1-1] != s[AW1-2])
      return s[AW1-1] ? A_MIN : A_MAX;
    return s[ACCUM_WIDTH-1:0];
  endfunction
`endif

  assign grp  = GW'(cnt - CW'(1));
  assign xfer = io.sample_valid_i & rdy;
  assign acc_out = ovld & io.out_ready_i;

  // Group g is handled at sweep cycle g+1; cycle 0 forms x*h.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BW-1:0]                 bin;
    logic signed [MW-1:0]          m_rr, m_ii, m_ri, m_ir;
    logic signed [PW-1:0]          p_re, p_im;
    logic signed [ACCUM_WIDTH-1:0] t_re, t_im;
    logic signed [NW-1:0]          n_rr, n_ii, n_ri, n_ir;
    logic signed [OW-1:0]          u_re, u_im;

    assign bin = BW'(int'(grp) * LANES + l);
    assign lane_bin[l] = bin;

    assign m_rr = MW'(xw_re) * MW'(w_re[bin]);
    assign m_ii = MW'(xw_im) * MW'(w_im[bin]);
    assign m_ri = MW'(xw_re) * MW'(w_im[bin]);
    assign m_ir = MW'(xw_im) * MW'(w_re[bin]);
    assign p_re = PW'(m_rr) - PW'(m_ii);
    assign p_im = PW'(m_ri) + PW'(m_ir);
    assign t_re = ACCUM_WIDTH'(p_re >>> SR);
    assign t_im = ACCUM_WIDTH'(p_im >>> SR);

    assign n_rr = NW'(w_re[bin]) * NW'(e_re[bin]);
    assign n_ii = NW'(w_im[bin]) * NW'(e_im[bin]);
    assign n_ri = NW'(w_re[bin]) * NW'(e_im[bin]);
    assign n_ir = NW'(w_im[bin]) * NW'(e_re[bin]);
    assign u_re = (OW'(n_rr) - OW'(n_ii) + W_RND) >>> FR;
    assign u_im = (OW'(n_ri) + OW'(n_ir) + W_RND) >>> FR;
    assign lane_w_re[l] = wsat(u_re);
    assign lane_w_im[l] = wsat(u_im);

`ifdef DFT_ACC_SAT_EN
    logic signed [AW1-1:0] s_re, s_im;
    assign s_re = AW1'(a_re[bin]) + AW1'(t_re);
    assign s_im = AW1'(a_im[bin]) + AW1'(t_im);
    assign lane_a_re[l] = asat(s_re);
    assign lane_a_im[l] = asat(s_im);
    assign lane_ovf[l]  = (s_re[AW1-1] != s_re[AW1-2]) |
                          (s_im[AW1-1] != s_im[AW1-2]);
`else
    assign lane_a_re[l] = a_re[bin] + t_re;
    assign lane_a_im[l] = a_im[bin] + t_im;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) st <= IDLE;
    else       st <= st_n;
  end

  always_comb begin
    st_n   = st;
    rdy    = 1'b0;
    ovld   = 1'b0;
    busy_o = (st != IDLE);
    unique case (st)
      IDLE: ;
      ACCUM: begin
        rdy = 1'b1;
        if (io.sample_valid_i) st_n = SWEEP;
      end
      SWEEP: begin
        if (cnt == CW'(G + 1)) st_n = x_last ? DRAIN : ACCUM;
      end
      DRAIN: begin
        ovld = 1'b1;
        if (io.out_ready_i && idx == BW'(NUM_BINS - 1)) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
    if (start_i) st_n = ACCUM;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        a_re[b] <= '0;
        a_im[b] <= '0;
        w_re[b] <= '0;
        w_im[b] <= '0;
        e_re[b] <= '0;
        e_im[b] <= '0;
      end
      cnt    <= '0;
      idx    <= '0;
      count  <= '0;
      x_i    <= '0;
      x_q    <= '0;
      x_h    <= '0;
      x_last <= 1'b0;
      xw_re  <= '0;
      xw_im  <= '0;
`ifdef DFT_ACC_SAT_EN
      ovf    <= 1'b0;
`endif
    end else if (start_i) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        a_re[b] <= '0;
        a_im[b] <= '0;
        w_re[b] <= W_ONE;
        w_im[b] <= '0;
        e_re[b] <= E_real_i[b];
        e_im[b] <= E_imag_i[b];
      end
      cnt   <= '0;
      idx   <= '0;
      count <= '0;
`ifdef DFT_ACC_SAT_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (st)
        ACCUM: begin
          if (xfer) begin
            x_i    <= io.i_sample_i;
            x_q    <= io.q_sample_i;
            x_h    <= io.window_coeff_i;
            x_last <= io.last_sample_i;
            cnt    <= '0;
            if (count != '1) count <= count + 1'b1;
          end
        end
        SWEEP: begin
          cnt <= cnt + 1'b1;
          if (cnt == '0) begin
            xw_re <= XW'(x_i) * XW'(x_h);
            xw_im <= XW'(x_q) * XW'(x_h);
          end else if (cnt <= CW'(G)) begin
            for (int l = 0; l < LANES; l++) begin
              a_re[lane_bin[l]] <= lane_a_re[l];
              a_im[lane_bin[l]] <= lane_a_im[l];
              w_re[lane_bin[l]] <= lane_w_re[l];
              w_im[lane_bin[l]] <= lane_w_im[l];
            end
`ifdef DFT_ACC_SAT_EN
            ovf <= ovf | (|lane_ovf);
`endif
          end
        end
        DRAIN: begin
          if (acc_out)
            idx <= (idx == BW'(NUM_BINS - 1)) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io.sample_ready_o = rdy;
  assign io.out_valid_o    = ovld;
  assign io.out_bin_o      = ovld ? idx : '0;
  assign io.out_real_o     = ovld ? a_re[idx] : '0;
  assign io.out_imag_o     = ovld ? a_im[idx] : '0;
  assign sample_count_o    = count;

`ifdef DFT_ACC_SAT_EN
  assign overflow_o = ovf;
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_dft_accumulation_tdm.sv
// Directed bench for dft_accumulation_tdm at default parameters.
module tb_dft_accumulation_tdm;

  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [NB-1:0][17:0] e_re, e_im;
  logic [15:0] count;
  logic busy, ovf;

  int passed = 0;
  int total  = 0;

  dft_accumulation_tdm_if io ();

  dft_accumulation_tdm dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .E_real_i       (e_re),
    .E_imag_i       (e_im),
    .io             (io),
    .sample_count_o (count),
    .busy_o         (busy),
    .overflow_o     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_e(input int re, input int im);
    for (int b = 0; b < NB; b++) begin
      e_re[b] = 18'(re);
      e_im[b] = 18'(im);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int i, input int q, input int h,
                      input bit last);
    int n = 0;
    io.sample_valid_i = 1'b1;
    io.i_sample_i     = 16'(i);
    io.q_sample_i     = 16'(q);
    io.window_coeff_i = 18'(h);
    io.last_sample_i  = last;
    while (!io.sample_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 64'(io.sample_ready_o), 1);
    @(negedge clk);
    io.sample_valid_i = 1'b0;
    io.last_sample_i  = 1'b0;
  endtask

  task automatic drain(input logic signed [63:0] er,
                       input logic signed [63:0] ei,
                       input int stall_bin);
    int n = 0;
    io.out_ready_i = 1'b1;
    while (!io.out_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_valid", 64'(io.out_valid_o), 1);
    for (int k = 0; k < NB; k++) begin
      if (k == stall_bin) begin
        io.out_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_bin", 64'(io.out_bin_o), k);
          chk("stall_re", io.out_real_o, er);
          chk("stall_valid", 64'(io.out_valid_o), 1);
        end
        io.out_ready_i = 1'b1;
      end
      chk($sformatf("bin%0d_idx", k), 64'(io.out_bin_o), k);
      chk($sformatf("bin%0d_re", k), io.out_real_o, er);
      chk($sformatf("bin%0d_im", k), io.out_imag_o, ei);
      @(negedge clk);
    end
    io.out_ready_i = 1'b0;
    chk("drain_busy", 64'(busy), 0);
    chk("drain_done", 64'(io.out_valid_o), 0);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    set_e(65536, 0);
    io.sample_valid_i = 1'b0;
    io.last_sample_i  = 1'b0;
    io.i_sample_i     = '0;
    io.q_sample_i     = '0;
    io.window_coeff_i = '0;
    io.out_ready_i    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(io.sample_ready_o), 0);
    chk("rst_valid", 64'(io.out_valid_o), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_re", io.out_real_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // reset during a sweep, with start held, must land in IDLE
    do_start();
    chk("start_busy", 64'(busy), 1);
    send(1000, 0, 1, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(io.sample_ready_o), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_count", 64'(count), 0);
    chk("midrst_valid", 64'(io.out_valid_o), 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_idle", 64'(busy), 0);

    // DC tone
    set_e(65536, 0);
    do_start();
    chk("dc_ready", 64'(io.sample_ready_o), 1);
    chk("dc_count0", 64'(count), 0);
    for (int s = 0; s < 4; s++) send(1000, 0, 1, s == 3);
    chk("dc_count", 64'(count), 4);
    drain(64'sd8192000, 64'sd0, -1);

    // abort mid-sweep via start, then quarter-turn rotation
    set_e(0, 65536);
    do_start();
    send(1000, 0, 1, 1'b0);
    do_start();
    chk("restart_count", 64'(count), 0);
    chk("restart_ready", 64'(io.sample_ready_o), 1);
    for (int s = 0; s < 4; s++) send(1000, 0, 1, s == 3);
    drain(64'sd0, 64'sd0, -1);

    // valid held high continuously
    set_e(65536, 0);
    do_start();
    io.sample_valid_i = 1'b1;
    io.i_sample_i     = 16'sd1000;
    io.q_sample_i     = 16'sd0;
    io.window_coeff_i = 18'sd1;
    io.last_sample_i  = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk("hs_ready", 64'(io.sample_ready_o), 1);
      @(negedge clk);
      n = 0;
      while (!io.sample_ready_o && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("hs_low_cycles", 64'(n), 6);
      chk("hs_count", 64'(count), t + 1);
    end
    send(1000, 0, 1, 1'b1);
    chk("hs_count4", 64'(count), 4);
    drain(64'sd8192000, 64'sd0, 5);

    // accumulator overflow
    set_e(65536, 0);
    do_start();
    chk("sat_ovf0", 64'(ovf), 0);
    for (int s = 0; s < 20; s++) send(32767, 0, 131071, s == 19);
    chk("sat_count", 64'(count), 20);
`ifdef DFT_ACC_SAT_EN
    chk("sat_ovf", 64'(ovf), 1);
    drain(64'sd140737488355327, 64'sd0, -1);
`else
    chk("sat_ovf", 64'(ovf), 0);
    drain(-64'sd105559827111936, 64'sd0, -1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
